decode_regfile: RTL and testbench

Decode/write-back stage of the sequential Y86-64 processor, directly downstream of instruction fetch. It consumes the fetched `icode`, `rA`, `rB` and the execute condition flag, selects source and destination register IDs, and reads `valA`/`valB` combinationally from a 15-entry, 64-bit register file. At the end of each enabled cycle it writes back `valE` and `valM`.

---
 rtl/decode_regfile_if.sv | 35 +++
 rtl/decode_regfile.sv | 119 +++++++++++
 tb/tb_decode_regfile.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/decode_regfile_if.sv
// ============================================================================
// decode_regfile_if : fetch/execute-facing bus of the Y86-64 decode stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface decode_regfile_if;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wr_en;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [3:0]  dbg_sel;
  logic [63:0] dbg_val;

  modport master (
    output icode, rA, rB, cnd, valE, valM, wr_en, dbg_sel,
    input  srcA, srcB, dstE, dstM, valA, valB, dbg_val
  );

  modport slave (
    input  icode, rA, rB, cnd, valE, valM, wr_en, dbg_sel,
    output srcA, srcB, dstE, dstM, valA, valB, dbg_val
  );
endinterface

`default_nettype wire

// File: rtl/decode_regfile.sv
// ============================================================================
// decode_regfile : Y86-64 decode / write-back stage with 64-bit register file
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_regfile #(
  parameter int NREG = 15
) (
  input  wire              clk,
  input  wire              rst,
  decode_regfile_if.slave  bus
);

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] RRSP    = 4'h4;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  logic [63:0] regs_q [NREG];
  logic [63:0] regs_d [NREG];

  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] val_a, val_b, dbg_val;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.icode)
      I_CMOV: begin
        src_a = bus.rA;
        dst_e = bus.cnd ? bus.rB : RNONE;
      end
      I_IRMOV: dst_e = bus.rB;
      I_RMMOV: begin
        src_a = bus.rA;
        src_b = bus.rB;
      end
      I_MRMOV: begin
        src_b = bus.rB;
        dst_m = bus.rA;
      end
      I_OPQ: begin
        src_a = bus.rA;
        src_b = bus.rB;
        dst_e = bus.rB;
      end
      I_CALL: begin
        src_b = RRSP;
        dst_e = RRSP;
      end
      I_RET: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
      end
      I_PUSH: begin
        src_a = bus.rA;
        src_b = RRSP;
        dst_e = RRSP;
      end
      I_POP: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
        dst_m = bus.rA;
      end
      default: ;
    endcase
  end

  // Reads see only pre-edge state; an ID with no backing register reads 0.
  always_comb begin
    val_a   = 64'd0;
    val_b   = 64'd0;
    dbg_val = 64'd0;
    for (int i = 0; i < NREG; i++) begin
      if (src_a == 4'(i))       val_a   = regs_q[i];
      if (src_b == 4'(i))       val_b   = regs_q[i];
      if (bus.dbg_sel == 4'(i)) dbg_val = regs_q[i];
    end
  end

  // The M port is applied after E so valM wins when both target one register.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (bus.wr_en && dst_e == 4'(i)) regs_d[i] = bus.valE;
      if (bus.wr_en && dst_m == 4'(i)) regs_d[i] = bus.valM;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) regs_q[i] <= 64'd0;
      else     regs_q[i] <= regs_d[i];
    end
  end

  assign bus.srcA    = src_a;
  assign bus.srcB    = src_b;
  assign bus.dstE    = dst_e;
  assign bus.dstM    = dst_m;
  assign bus.valA    = val_a;
  assign bus.valB    = val_b;
  assign bus.dbg_val = dbg_val;

endmodule

`default_nettype wire

// File: tb/tb_decode_regfile.sv
// ============================================================================
// tb_decode_regfile : directed self-checking bench for decode_regfile
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_decode_regfile;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  decode_regfile_if bus ();

  decode_regfile #(.NREG(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm,
                       input logic we);
    bus.icode = ic;
    bus.rA    = ra;
    bus.rB    = rb;
    bus.cnd   = c;
    bus.valE  = ve;
    bus.valM  = vm;
    bus.wr_en = we;
    #1;
  endtask

  task automatic check_dbg(input string tag, input logic [3:0] sel, input logic [63:0] exp);
    bus.dbg_sel = sel;
    #1;
    check(tag, bus.dbg_val, exp);
  endtask

  initial begin
    rst         = 1'b1;
    bus.dbg_sel = 4'hF;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 15; i++) check_dbg($sformatf("init_reg%0d", i), 4'(i), 64'd0);
    check_dbg("dbg_none", 4'hF, 64'd0);

    // write 0x1234 to reg 3, then reset while another write is pending
    drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h1234, 64'd0, 1'b1);
    check("irmov_dste3", bus.dstE, 64'h3);
    step();
    drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h5555, 64'd0, 1'b1);
    check_dbg("reg3_written", 4'h3, 64'h1234);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    check_dbg("reset_reg3", 4'h3, 64'd0);
    for (int i = 0; i < 15; i++) check_dbg($sformatf("post_rst_reg%0d", i), 4'(i), 64'd0);

    // irmovq $16, %rdx
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'd16, 64'd0, 1'b1);
    check("irmov_dstE", bus.dstE, 64'h2);
    check("irmov_dstM", bus.dstM, 64'hF);
    check("irmov_srcA", bus.srcA, 64'hF);
    step();
    drive(4'h6, 4'h2, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    check("opq_srcA", bus.srcA, 64'h2);
    check("opq_valA", bus.valA, 64'd16);
    check("opq_valB_none", bus.valB, 64'd0);

    // cmov gating on cnd
    drive(4'h2, 4'h2, 4'h6, 1'b0, 64'd5, 64'd0, 1'b1);
    check("cmov0_dstE", bus.dstE, 64'hF);
    check("cmov0_srcA", bus.srcA, 64'h2);
    check("cmov0_valA", bus.valA, 64'd16);
    step();
    bus.wr_en = 1'b0;
    check_dbg("cmov0_reg6", 4'h6, 64'd0);
    drive(4'h2, 4'h2, 4'h6, 1'b1, 64'd5, 64'd0, 1'b1);
    check("cmov1_dstE", bus.dstE, 64'h6);
    step();
    bus.wr_en = 1'b0;
    check_dbg("cmov1_reg6", 4'h6, 64'd5);

    // popq %rsp: valM beats valE
    drive(4'h3, 4'hF, 4'h4, 1'b0, 64'd100, 64'd0, 1'b1);
    step();
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'd108, 64'd77, 1'b1);
    check("pop_srcA", bus.srcA, 64'h4);
    check("pop_srcB", bus.srcB, 64'h4);
    check("pop_dstE", bus.dstE, 64'h4);
    check("pop_dstM", bus.dstM, 64'h4);
    check("pop_valA", bus.valA, 64'd100);
    step();
    bus.wr_en = 1'b0;
    check_dbg("pop_reg4", 4'h4, 64'd77);

    // call then ret
    drive(4'h8, 4'hF, 4'hF, 1'b0, 64'd92, 64'd0, 1'b1);
    check("call_srcB", bus.srcB, 64'h4);
    check("call_dstE", bus.dstE, 64'h4);
    check("call_srcA", bus.srcA, 64'hF);
    check("call_dstM", bus.dstM, 64'hF);
    check("call_valB", bus.valB, 64'd77);
    step();
    bus.wr_en = 1'b0;
    check_dbg("call_reg4", 4'h4, 64'd92);
    drive(4'h9, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    check("ret_srcA", bus.srcA, 64'h4);
    check("ret_srcB", bus.srcB, 64'h4);
    check("ret_valA", bus.valA, 64'd92);
    check("ret_valB", bus.valB, 64'd92);

    // pushq and mrmovq decode
    drive(4'hA, 4'h6, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    check("push_srcA", bus.srcA, 64'h6);
    check("push_valA", bus.valA, 64'd5);
    check("push_dstE", bus.dstE, 64'h4);
    drive(4'h5, 4'h7, 4'h2, 1'b0, 64'd0, 64'hDEAD, 1'b1);
    check("mrmov_srcB", bus.srcB, 64'h2);
    check("mrmov_valB", bus.valB, 64'd16);
    check("mrmov_dstM", bus.dstM, 64'h7);
    check("mrmov_dstE", bus.dstE, 64'hF);
    step();
    bus.wr_en = 1'b0;
    check_dbg("mrmov_reg7", 4'h7, 64'hDEAD);

    // stall and halt leave reg 3 alone
    drive(4'h3, 4'hF, 4'h3, 1'b0, 64'd33, 64'd0, 1'b1);
    step();
    drive(4'h6, 4'h2, 4'h3, 1'b0, 64'd9, 64'd0, 1'b0);
    check("stall_dstE", bus.dstE, 64'h3);
    step();
    check_dbg("stall_reg3", 4'h3, 64'd33);
    drive(4'h0, 4'h3, 4'h3, 1'b1, 64'd9, 64'd9, 1'b1);
    check("halt_srcA", bus.srcA, 64'hF);
    check("halt_srcB", bus.srcB, 64'hF);
    check("halt_dstE", bus.dstE, 64'hF);
    check("halt_dstM", bus.dstM, 64'hF);
    check("halt_valA", bus.valA, 64'd0);
    check("halt_valB", bus.valB, 64'd0);
    step();
    check_dbg("halt_reg3", 4'h3, 64'd33);

    // undefined icode selects nothing
    drive(4'hC, 4'h3, 4'h3, 1'b1, 64'd1, 64'd1, 1'b1);
    check("undef_srcA", bus.srcA, 64'hF);
    check("undef_dstE", bus.dstE, 64'hF);
    check("undef_dstM", bus.dstM, 64'hF);
    step();
    check_dbg("undef_reg3", 4'h3, 64'd33);
    check_dbg("dbg_none_end", 4'hF, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
